// File: rtl/l2_port_arbiter_pkg.sv
// rtl/l2_port_arbiter_pkg.sv - shared types and widths for the L2 port arbiter
package l2_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;

  localparam int DEF_LINE_W = 128;

  localparam int TO_CNT_W = 8;

  // rr_last encoding: which read port won the previous read arbitration
  localparam logic RR_P2 = 1'b0;
  localparam logic RR_P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    G_P2_RD = 2'd0,
    G_P1_RD = 2'd1,
    G_P1_WR = 2'd2
  } arb_grant_t;

endpackage

// File: rtl/l2_port_arbiter_rr_arb2.sv
// rtl/l2_port_arbiter_rr_arb2.sv - 2-way round-robin picker; bit0 = p2 read, bit1 = p1 read
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // on a collision the port that did not win last time goes first
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - shares one L2 port between L1I reads and L1D reads/write-backs
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_p2_i,
  input  logic [ADDR_W-1:0] raddr_p2_i,
  output logic [LINE_W-1:0] rdata_p2_o,
  output logic              read_hit_p2_o,
  input  logic              re_p1_i,
  input  logic [ADDR_W-1:0] raddr_p1_i,
  output logic [LINE_W-1:0] rdata_p1_o,
  output logic              read_hit_p1_o,
  input  logic              we_p1_i,
  input  logic [ADDR_W-1:0] waddr_p1_i,
  input  logic [LINE_W-1:0] wdata_p1_i,
  output logic              write_hit_p1_o,
  output logic              re_m_o,
  output logic [ADDR_W-1:0] raddr_m_o,
  input  logic [LINE_W-1:0] rdata_m_i,
  input  logic              read_hit_m_i,
  output logic              we_m_o,
  output logic [ADDR_W-1:0] waddr_m_o,
  output logic [LINE_W-1:0] wdata_m_o,
  input  logic              write_hit_m_i,
  output logic              busy_o,
  output logic              err_timeout_o
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  arb_state_t          r_state, w_state_n;
  arb_grant_t          r_grant, w_grant_n;
  logic [TO_CNT_W-1:0] r_cnt, w_cnt_n;
  logic                r_rr_last, w_rr_last_n;
  logic                r_re_m, w_re_m_n;
  logic                r_we_m, w_we_m_n;
  logic [ADDR_W-1:0]   r_raddr_m, w_raddr_n;
  logic [ADDR_W-1:0]   r_waddr_m, w_waddr_n;
  logic [LINE_W-1:0]   r_wdata_m, w_wdata_n;
  logic [LINE_W-1:0]   r_rdata_p2, w_rdata_p2_n;
  logic [LINE_W-1:0]   r_rdata_p1, w_rdata_p1_n;
  logic                r_hit_p2, w_hit_p2_n;
  logic                r_hit_p1, w_hit_p1_n;
  logic                r_whit_p1, w_whit_p1_n;
  logic                r_err, w_err_n;
  logic                r_busy;
  logic [1:0]          w_req, w_rr_gnt;

  assign w_req = {re_p1_i, re_p2_i};

  rr_arb2 u_rr_arb2 (
    .i_req   (w_req),
    .i_last  (r_rr_last),
    .o_grant (w_rr_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= G_P2_RD;
      r_cnt      <= '0;
      r_rr_last  <= RR_P1;
      r_re_m     <= 1'b0;
      r_we_m     <= 1'b0;
      r_raddr_m  <= '0;
      r_waddr_m  <= '0;
      r_wdata_m  <= '0;
      r_rdata_p2 <= '0;
      r_rdata_p1 <= '0;
      r_hit_p2   <= 1'b0;
      r_hit_p1   <= 1'b0;
      r_whit_p1  <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_grant    <= w_grant_n;
      r_cnt      <= w_cnt_n;
      r_rr_last  <= w_rr_last_n;
      r_re_m     <= w_re_m_n;
      r_we_m     <= w_we_m_n;
      r_raddr_m  <= w_raddr_n;
      r_waddr_m  <= w_waddr_n;
      r_wdata_m  <= w_wdata_n;
      r_rdata_p2 <= w_rdata_p2_n;
      r_rdata_p1 <= w_rdata_p1_n;
      r_hit_p2   <= w_hit_p2_n;
      r_hit_p1   <= w_hit_p1_n;
      r_whit_p1  <= w_whit_p1_n;
      r_err      <= w_err_n;
      r_busy     <= (w_state_n != IDLE);
    end
  end

  // Outputs are computed as next-state values so every port is driven from a flop.
  always_comb begin
    w_state_n    = r_state;
    w_grant_n    = r_grant;
    w_cnt_n      = r_cnt;
    w_rr_last_n  = r_rr_last;
    w_raddr_n    = r_raddr_m;
    w_waddr_n    = r_waddr_m;
    w_wdata_n    = r_wdata_m;
    w_rdata_p2_n = r_rdata_p2;
    w_rdata_p1_n = r_rdata_p1;
    w_re_m_n     = 1'b0;
    w_we_m_n     = 1'b0;
    w_hit_p2_n   = 1'b0;
    w_hit_p1_n   = 1'b0;
    w_whit_p1_n  = 1'b0;
    w_err_n      = 1'b0;
    case (r_state)
      IDLE: begin
        if (we_p1_i) begin
          w_grant_n = G_P1_WR;
          w_waddr_n = waddr_p1_i;
          w_wdata_n = wdata_p1_i;
          w_we_m_n  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = ISSUE;
        end else if (w_rr_gnt[0]) begin
          w_grant_n   = G_P2_RD;
          w_raddr_n   = raddr_p2_i;
          w_rr_last_n = RR_P2;
          w_re_m_n    = 1'b1;
          w_cnt_n     = '0;
          w_state_n   = ISSUE;
        end else if (w_rr_gnt[1]) begin
          w_grant_n   = G_P1_RD;
          w_raddr_n   = raddr_p1_i;
          w_rr_last_n = RR_P1;
          w_re_m_n    = 1'b1;
          w_cnt_n     = '0;
          w_state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (r_grant == G_P1_WR) begin
          if (write_hit_m_i) begin
            w_whit_p1_n = 1'b1;
            w_state_n   = RESP;
          end else if (r_cnt == TO_LAST) begin
            w_err_n   = 1'b1;
            w_state_n = DRAIN;
          end else begin
            w_cnt_n  = r_cnt + TO_CNT_W'(1);
            w_we_m_n = 1'b1;
          end
        end else begin
          if (read_hit_m_i) begin
            w_state_n = RESP;
            if (r_grant == G_P2_RD) begin
              w_hit_p2_n   = 1'b1;
              w_rdata_p2_n = rdata_m_i;
            end else begin
              w_hit_p1_n   = 1'b1;
              w_rdata_p1_n = rdata_m_i;
            end
          end else if (r_cnt == TO_LAST) begin
            w_err_n   = 1'b1;
            w_state_n = DRAIN;
          end else begin
            w_cnt_n  = r_cnt + TO_CNT_W'(1);
            w_re_m_n = 1'b1;
          end
        end
      end
      RESP:    w_state_n = DRAIN;
      DRAIN:   w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  assign re_m_o         = r_re_m;
  assign we_m_o         = r_we_m;
  assign raddr_m_o      = r_raddr_m;
  assign waddr_m_o      = r_waddr_m;
  assign wdata_m_o      = r_wdata_m;
  assign rdata_p2_o     = r_rdata_p2;
  assign rdata_p1_o     = r_rdata_p1;
  assign read_hit_p2_o  = r_hit_p2;
  assign read_hit_p1_o  = r_hit_p1;
  assign write_hit_p1_o = r_whit_p1;
  assign busy_o         = r_busy;
  assign err_timeout_o  = r_err;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          re_p2_i = 1'b0, re_p1_i = 1'b0, we_p1_i = 1'b0;
  logic [AW-1:0] raddr_p2_i = '0, raddr_p1_i = '0, waddr_p1_i = '0;
  logic [LW-1:0] wdata_p1_i = '0, rdata_m_i = '0;
  logic          read_hit_m_i = 1'b0, write_hit_m_i = 1'b0;
  logic [LW-1:0] rdata_p2_o, rdata_p1_o, wdata_m_o;
  logic [AW-1:0] raddr_m_o, waddr_m_o;
  logic          read_hit_p2_o, read_hit_p1_o, write_hit_p1_o;
  logic          re_m_o, we_m_o, busy_o, err_timeout_o;

  int n_vec = 0;
  int n_err = 0;

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .re_p2_i        (re_p2_i),
    .raddr_p2_i     (raddr_p2_i),
    .rdata_p2_o     (rdata_p2_o),
    .read_hit_p2_o  (read_hit_p2_o),
    .re_p1_i        (re_p1_i),
    .raddr_p1_i     (raddr_p1_i),
    .rdata_p1_o     (rdata_p1_o),
    .read_hit_p1_o  (read_hit_p1_o),
    .we_p1_i        (we_p1_i),
    .waddr_p1_i     (waddr_p1_i),
    .wdata_p1_i     (wdata_p1_i),
    .write_hit_p1_o (write_hit_p1_o),
    .re_m_o         (re_m_o),
    .raddr_m_o      (raddr_m_o),
    .rdata_m_i      (rdata_m_i),
    .read_hit_m_i   (read_hit_m_i),
    .we_m_o         (we_m_o),
    .waddr_m_o      (waddr_m_o),
    .wdata_m_o      (wdata_m_o),
    .write_hit_m_i  (write_hit_m_i),
    .busy_o         (busy_o),
    .err_timeout_o  (err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_m(input bit wr);
    for (int i = 0; i < 16; i++) begin
      if (wr ? we_m_o : re_m_o) break;
      step();
    end
    chk(wr ? "we_m_seen" : "re_m_seen", LW'(wr ? we_m_o : re_m_o), LW'(1));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] d, input int lat, input int port);
    logic [LW-1:0] rd;
    wait_m(1'b0);
    chk("raddr_m", LW'(raddr_m_o), LW'(a));
    chk("we_m_idle_in_read", LW'(we_m_o), '0);
    repeat (lat) step();
    chk("re_m_held", LW'(re_m_o), LW'(1));
    rdata_m_i = d;
    read_hit_m_i = 1'b1;
    step();
    read_hit_m_i = 1'b0;
    rdata_m_i = '0;
    rd = (port == 2) ? rdata_p2_o : rdata_p1_o;
    chk("hit_p2", LW'(read_hit_p2_o), LW'(port == 2));
    chk("hit_p1", LW'(read_hit_p1_o), LW'(port == 1));
    chk("rdata_port", rd, d);
    chk("re_m_dropped", LW'(re_m_o), '0);
    if (port == 2) re_p2_i = 1'b0;
    else re_p1_i = 1'b0;
    step();
    chk("hit_one_cycle", LW'(read_hit_p2_o | read_hit_p1_o), '0);
    chk("busy_drain", LW'(busy_o), LW'(1));
    step();
    chk("busy_idle", LW'(busy_o), '0);
  endtask

  logic [LW-1:0] d_a5, d_3c, d_55, d_77;
  bit            seen;

  initial begin
    d_a5 = {16{8'hA5}};
    d_3c = {16{8'h3C}};
    d_55 = {16{8'h55}};
    d_77 = {16{8'h77}};

    step();
    chk("rst_re_m", LW'(re_m_o), '0);
    chk("rst_we_m", LW'(we_m_o), '0);
    chk("rst_busy", LW'(busy_o), '0);
    chk("rst_rdata_p2", rdata_p2_o, '0);
    chk("rst_err", LW'(err_timeout_o), '0);
    rst = 1'b0;
    step();

    // L2 hits while idle must not produce any requester pulse
    read_hit_m_i = 1'b1; write_hit_m_i = 1'b1; rdata_m_i = '1;
    step();
    read_hit_m_i = 1'b0; write_hit_m_i = 1'b0; rdata_m_i = '0;
    chk("idle_hit_p2", LW'(read_hit_p2_o), '0);
    chk("idle_whit", LW'(write_hit_p1_o), '0);
    chk("idle_busy", LW'(busy_o), '0);
    chk("idle_rdata_p2", rdata_p2_o, '0);

    // collision after reset: rr_last=p1 so p2 wins, L2 hit 3 cycles after re_m_o
    re_p2_i = 1'b1; raddr_p2_i = 32'h40;
    re_p1_i = 1'b1; raddr_p1_i = 32'hC0;
    do_read(32'h40, d_a5, 3, 2);
    do_read(32'hC0, d_3c, 1, 1);
    chk("rdata_p2_hold", rdata_p2_o, d_a5);

    // solo p2 read, then collision: p1 now wins
    re_p2_i = 1'b1; raddr_p2_i = 32'h48;
    do_read(32'h48, d_77, 2, 2);
    re_p2_i = 1'b1; raddr_p2_i = 32'h44;
    re_p1_i = 1'b1; raddr_p1_i = 32'hC4;
    do_read(32'hC4, d_55, 1, 1);
    do_read(32'h44, d_3c, 1, 2);

    // write-back beats a simultaneous p2 read
    we_p1_i = 1'b1; waddr_p1_i = 32'h80; wdata_p1_i = d_55;
    re_p2_i = 1'b1; raddr_p2_i = 32'h50;
    wait_m(1'b1);
    chk("waddr_m", LW'(waddr_m_o), LW'(32'h80));
    chk("wdata_m", wdata_m_o, d_55);
    chk("re_m_off_in_write", LW'(re_m_o), '0);
    step();
    write_hit_m_i = 1'b1;
    step();
    write_hit_m_i = 1'b0;
    chk("whit_p1", LW'(write_hit_p1_o), LW'(1));
    chk("whit_no_rd_hit", LW'(read_hit_p2_o | read_hit_p1_o), '0);
    chk("we_m_dropped", LW'(we_m_o), '0);
    we_p1_i = 1'b0;
    step();
    chk("whit_one_cycle", LW'(write_hit_p1_o), '0);
    step();
    do_read(32'h50, d_a5, 1, 2);

    // write_hit_m_i during a read must be ignored
    re_p1_i = 1'b1; raddr_p1_i = 32'h90;
    wait_m(1'b0);
    write_hit_m_i = 1'b1;
    step();
    write_hit_m_i = 1'b0;
    chk("spur_whit", LW'(write_hit_p1_o), '0);
    chk("spur_rhit", LW'(read_hit_p1_o), '0);
    chk("spur_re_m", LW'(re_m_o), LW'(1));
    do_read(32'h90, d_77, 1, 1);
    chk("rdata_p1_hold_after", rdata_p1_o, d_77);

    // watchdog: 255 ISSUE cycles without a hit, then retry
    re_p2_i = 1'b1; raddr_p2_i = 32'h60;
    wait_m(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 254; i++) begin
      step();
      if (err_timeout_o || !re_m_o) seen = 1'b1;
    end
    chk("to_no_early_abort", LW'(seen), '0);
    step();
    chk("to_err_pulse", LW'(err_timeout_o), LW'(1));
    chk("to_re_m_low", LW'(re_m_o), '0);
    chk("to_no_hit", LW'(read_hit_p2_o), '0);
    step();
    chk("to_err_one_cycle", LW'(err_timeout_o), '0);
    do_read(32'h60, d_55, 1, 2);

    // asynchronous reset in the middle of ISSUE
    re_p1_i = 1'b1; raddr_p1_i = 32'hA0;
    wait_m(1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_re_m", LW'(re_m_o), '0);
    chk("arst_busy", LW'(busy_o), '0);
    chk("arst_rdata_p2", rdata_p2_o, '0);
    step();
    rst = 1'b0;
    do_read(32'hA0, d_a5, 2, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (re_m_o || we_m_o) seen = 1'b1;
    end
    chk("arst_served_once", LW'(seen), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
